// File: rtl/mmio_console.sv
// mmio_console: memory-mapped console peripheral on the CPU data-memory bus.
// A 16-byte register window (TXDATA, STATUS, CYCLE, CTRL) sits at BASE.
// Bytes stored to TXDATA are queued in a FIFO and leave on a valid/ready
// byte stream. A free-running 32-bit cycle counter is also readable.
module mmio_console #(
    parameter logic [31:0] BASE  = 32'h0001_0000,
    parameter int          DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  func_in,
    input  logic [2:0]  func_out,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        hit,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] OFF_TX     = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLE  = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SW = 2'b10;
    localparam logic [1:0] ST_RSV = 2'b11;

    typedef enum logic {IDLE, PRESENT} state_t;

    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          enable;
    logic [31:0]   cycle;
    state_t        state_q;
    state_t        state_d;

    logic [1:0]    offset;
    logic          wr_en;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          can_load;
    logic          full;
    logic          empty;
    logic          ovf_set;
    logic          ovf_clr;

    logic [31:0]   word;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   fmt;

    // Sign-extend a byte lane to a full word.
    function automatic logic [31:0] sext_byte(input logic signed [7:0] b);
        logic signed [31:0] w;
        w = b;
        return w;
    endfunction

    // Sign-extend a halfword lane to a full word.
    function automatic logic [31:0] sext_half(input logic signed [15:0] h);
        logic signed [31:0] w;
        w = h;
        return w;
    endfunction

    assign offset   = address[3:2];
    assign hit      = (address[31:4] == BASE[31:4]);
    // Reserved store width is treated as no store at all.
    assign wr_en    = we && hit && (func_in != ST_RSV);
    assign push_req = wr_en && (offset == OFF_TX);
    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign can_load = enable && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = wr_en && (offset == OFF_CTRL) && data_in[2];

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end

    // FIFO storage; contents are meaningless outside the pointer range.
    always_ff @(posedge clock) begin
        if (push_ok) fifo_mem[wr_ptr] <= data_in[7:0];
    end

    // Sticky overflow and enable; a new overflow beats a clear in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
            enable   <= 1'b0;
        end else begin
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            if (wr_en && (offset == OFF_CTRL)) enable <= data_in[0];
        end
    end

    // Free-running cycle counter; a word store overrides the increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle <= '0;
        end else if (wr_en && (offset == OFF_CYCLE) && (func_in == ST_SW)) begin
            cycle <= data_in;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

    // Output stage state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Output stage next state: stay presenting while bytes keep flowing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (can_load) state_d = PRESENT;
            PRESENT: if (out_ready && !can_load) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output stage outputs: valid while presenting, pop whenever a load happens.
    always_comb begin
        out_valid = (state_q == PRESENT);
        pop       = can_load && ((state_q == IDLE) || out_ready);
    end

    // Presented byte register; only changes on a load so it stays stable.
    always_ff @(posedge clock) begin
        if (reset)    out_data <= 8'h00;
        else if (pop) out_data <= fifo_mem[rd_ptr];
    end

    // Combinational read path: word select, lane extraction, extension.
    always_comb begin
        word = '0;
        unique case (offset)
            OFF_TX:     word = '0;
            OFF_STATUS: word = {16'h0000, 8'(count), 5'b00000, overflow, full, empty};
            OFF_CYCLE:  word = cycle;
            OFF_CTRL:   word = {31'b0, enable};
            default:    word = '0;
        endcase
        lane_b = 8'(word >> {address[1:0], 3'b000});
        lane_h = 16'(word >> {address[1], 4'b0000});
        unique case (func_out)
            3'b000:  fmt = sext_byte(lane_b);
            3'b001:  fmt = sext_half(lane_h);
            3'b010:  fmt = word;
            3'b100:  fmt = {24'h000000, lane_b};
            3'b101:  fmt = {16'h0000, lane_h};
            default: fmt = '0;
        endcase
        data_out = hit ? fmt : 32'h0000_0000;
    end

endmodule

// File: tb/tb_mmio_console.sv
// Testbench for mmio_console: read-format vector table, directed multi-cycle
// sequences, and a randomized run against a queue-based reference model.
module tb_mmio_console;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  func_in = 2'b00;
    logic [2:0]  func_out = 3'b010;
    logic [31:0] address = 32'h0;
    logic [31:0] data_in = 32'h0;
    logic [31:0] data_out;
    logic        hit;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    mmio_console #(.BASE(BASE), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .we(we), .func_in(func_in),
        .func_out(func_out), .address(address), .data_in(data_in),
        .data_out(data_out), .hit(hit), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready)
    );

    always #100 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  fo;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[$];

    // reference model state
    logic [7:0]  mq[$];
    bit          m_ovf;
    bit          m_en;
    bit          m_pv;
    logic [7:0]  m_pd;
    logic [31:0] m_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; we = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] f);
        address = a; data_in = d; func_in = f; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] f, output logic [31:0] d);
        address = a; func_out = f;
        #1;
        d = data_out;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] f);
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] h;
        int n;
        if (a[31:4] != BASE[31:4]) return 32'h0;
        n = mq.size();
        case (a[3:2])
            2'd1: w = 32'(n) * 256 + (m_ovf ? 4 : 0) + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0);
            2'd2: w = m_cyc;
            2'd3: w = m_en ? 32'd1 : 32'd0;
            default: w = 32'h0;
        endcase
        b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (f)
            3'b000: return (b >= 128) ? b - 32'd256 : b;
            3'b001: return (h >= 32768) ? h - 32'd65536 : h;
            3'b010: return w;
            3'b100: return b;
            3'b101: return h;
            default: return 32'h0;
        endcase
    endfunction

    // advance the model by one clock edge using the inputs currently applied
    task automatic model_step();
        bit wr;
        bit take;
        bit was_full;
        bit ovf_new;
        if (reset) begin
            mq.delete(); m_ovf = 0; m_en = 0; m_cyc = 0; m_pv = 0; m_pd = 8'h00;
            return;
        end
        wr = we && (address[31:4] == BASE[31:4]) && (func_in != 2'b11);
        take = m_en && (mq.size() > 0) && (!m_pv || out_ready);
        was_full = (mq.size() == DEPTH);
        ovf_new = 0;
        if (take) begin
            m_pd = mq.pop_front();
            m_pv = 1;
        end else if (m_pv && out_ready) begin
            m_pv = 0;
        end
        if (wr && address[3:2] == 2'd0) begin
            if (!was_full || take) mq.push_back(data_in[7:0]);
            else ovf_new = 1;
        end
        if (ovf_new) m_ovf = 1;
        else if (wr && address[3:2] == 2'd3 && data_in[2]) m_ovf = 0;
        if (wr && address[3:2] == 2'd3) m_en = data_in[0];
        if (wr && address[3:2] == 2'd2 && func_in == 2'b10) m_cyc = data_in;
        else m_cyc = m_cyc + 32'd1;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] v;
        logic [7:0]  got[$];

        // reset state and cycle count after 5 idle cycles
        do_reset();
        repeat (5) tick();
        load(BASE + 32'h8, 3'b010, rd); check("cycle_after_5", rd, 32'd5);
        load(BASE + 32'h4, 3'b010, rd); check("status_reset", rd, 32'h0000_0001);
        load(BASE + 32'hC, 3'b010, rd); check("ctrl_reset", rd, 32'h0);
        check("valid_reset", 32'(out_valid), 32'd0);
        check("data_reset", 32'(out_data), 32'h0);

        // read-format table; CYCLE holds 0x80F17F82 until the next edge
        vecs.push_back('{BASE + 32'h8,  3'b010, 32'h80F1_7F82});
        vecs.push_back('{BASE + 32'h8,  3'b000, 32'hFFFF_FF82});
        vecs.push_back('{BASE + 32'h8,  3'b100, 32'h0000_0082});
        vecs.push_back('{BASE + 32'h9,  3'b000, 32'h0000_007F});
        vecs.push_back('{BASE + 32'hA,  3'b000, 32'hFFFF_FFF1});
        vecs.push_back('{BASE + 32'hB,  3'b100, 32'h0000_0080});
        vecs.push_back('{BASE + 32'hB,  3'b000, 32'hFFFF_FF80});
        vecs.push_back('{BASE + 32'h8,  3'b001, 32'h0000_7F82});
        vecs.push_back('{BASE + 32'h9,  3'b001, 32'h0000_7F82});
        vecs.push_back('{BASE + 32'hA,  3'b001, 32'hFFFF_80F1});
        vecs.push_back('{BASE + 32'hA,  3'b101, 32'h0000_80F1});
        vecs.push_back('{BASE + 32'h8,  3'b011, 32'h0});
        vecs.push_back('{BASE + 32'h8,  3'b110, 32'h0});
        vecs.push_back('{BASE + 32'h8,  3'b111, 32'h0});
        vecs.push_back('{BASE + 32'h0,  3'b010, 32'h0});
        vecs.push_back('{BASE + 32'h4,  3'b000, 32'h0000_0001});
        vecs.push_back('{BASE + 32'h5,  3'b100, 32'h0});
        vecs.push_back('{BASE + 32'hC,  3'b010, 32'h0});
        vecs.push_back('{BASE + 32'h18, 3'b010, 32'h0});
        vecs.push_back('{BASE - 32'h4,  3'b010, 32'h0});
        store(BASE + 32'h8, 32'h80F1_7F82, 2'b10);
        for (int i = 0; i < vecs.size(); i++) begin
            load(vecs[i].addr, vecs[i].fo, rd);
            check($sformatf("rdvec[%0d]", i), rd, vecs[i].exp);
        end

        // queue three bytes while disabled, then enable and drain
        do_reset();
        store(BASE, 32'h41, 2'b00);
        store(BASE, 32'h42, 2'b00);
        store(BASE, 32'h43, 2'b00);
        load(BASE + 32'h4, 3'b010, rd); check("status_3q", rd, 32'h0000_0300);
        check("valid_disabled", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        store(BASE + 32'hC, 32'h1, 2'b00);
        check("valid_at_ctrl", 32'(out_valid), 32'd0);
        tick(); check("valid_b0", 32'(out_valid), 32'd1); check("data_b0", 32'(out_data), 32'h41);
        tick(); check("valid_b1", 32'(out_valid), 32'd1); check("data_b1", 32'(out_data), 32'h42);
        tick(); check("valid_b2", 32'(out_valid), 32'd1); check("data_b2", 32'(out_data), 32'h43);
        tick(); check("valid_done", 32'(out_valid), 32'd0);
        load(BASE + 32'h4, 3'b010, rd); check("status_drained", rd, 32'h0000_0001);

        // overflow: nine stores into an eight-deep FIFO
        do_reset();
        for (int i = 0; i < 9; i++) store(BASE, 32'(i), 2'b00);
        load(BASE + 32'h4, 3'b010, rd); check("status_ovf", rd, 32'h0000_0806);
        out_ready = 1'b1;
        store(BASE + 32'hC, 32'h5, 2'b10);
        load(BASE + 32'h4, 3'b010, rd); check("status_ovf_clr", rd, 32'h0000_0802);
        load(BASE + 32'hC, 3'b010, rd); check("ctrl_en", rd, 32'h1);
        got.delete();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) got.push_back(out_data);
        end
        check("ovf_drain_cnt", 32'(got.size()), 32'd8);
        for (int i = 0; i < got.size() && i < 8; i++)
            check($sformatf("ovf_byte[%0d]", i), 32'(got[i]), 32'(i));
        load(BASE + 32'h4, 3'b010, rd); check("status_ovf_empty", rd, 32'h0000_0001);

        // presented byte held through stall and enable clear
        do_reset();
        store(BASE, 32'h41, 2'b00);
        store(BASE, 32'h42, 2'b00);
        store(BASE, 32'h43, 2'b00);
        store(BASE + 32'hC, 32'h1, 2'b10);
        tick();
        check("hold_valid0", 32'(out_valid), 32'd1); check("hold_data0", 32'(out_data), 32'h41);
        store(BASE + 32'hC, 32'h0, 2'b10);
        check("hold_valid1", 32'(out_valid), 32'd1); check("hold_data1", 32'(out_data), 32'h41);
        tick(); tick();
        check("hold_valid2", 32'(out_valid), 32'd1); check("hold_data2", 32'(out_data), 32'h41);
        out_ready = 1'b1;
        tick();
        check("hold_release", 32'(out_valid), 32'd0);
        load(BASE + 32'h4, 3'b010, rd); check("hold_status", rd, 32'h0000_0200);
        out_ready = 1'b0;

        // cycle counter wrap and width rules
        store(BASE + 32'h8, 32'hFFFF_FFFE, 2'b10);
        load(BASE + 32'h8, 3'b010, rd); check("cyc_set", rd, 32'hFFFF_FFFE);
        tick(); load(BASE + 32'h8, 3'b010, rd); check("cyc_max", rd, 32'hFFFF_FFFF);
        tick(); load(BASE + 32'h8, 3'b010, rd); check("cyc_wrap", rd, 32'h0);
        load(BASE + 32'h8, 3'b010, v);
        store(BASE + 32'h8, 32'h1234, 2'b01);
        load(BASE + 32'h8, 3'b010, rd); check("cyc_sh_ignored", rd, v + 32'd1);
        store(BASE + 32'h8, 32'h0000_8000, 2'b10);
        load(BASE + 32'h9, 3'b100, rd); check("cyc_lbu", rd, 32'h0000_0080);
        load(BASE + 32'h9, 3'b000, rd); check("cyc_lb", rd, 32'hFFFF_FF80);

        // miss store and reset mid-transfer
        do_reset();
        store(BASE + 32'h10, 32'h55, 2'b00);
        load(BASE + 32'h4, 3'b010, rd); check("miss_status", rd, 32'h0000_0001);
        load(BASE + 32'h10, 3'b010, rd); check("miss_data", rd, 32'h0);
        check("miss_hit", 32'(hit), 32'd0);
        store(BASE + 32'hC, 32'h1, 2'b00);
        store(BASE, 32'hA0, 2'b00);
        store(BASE, 32'hA1, 2'b00);
        store(BASE, 32'hA2, 2'b00);
        store(BASE, 32'hA3, 2'b00);
        check("mid_valid", 32'(out_valid), 32'd1);
        load(BASE + 32'h4, 3'b010, rd); check("mid_status", rd, 32'h0000_0300);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'h0);
        load(BASE + 32'h4, 3'b010, rd); check("rst_status", rd, 32'h0000_0001);
        load(BASE + 32'hC, 3'b010, rd); check("rst_ctrl", rd, 32'h0);

        // randomized run against the reference model
        do_reset();
        mq.delete(); m_ovf = 0; m_en = 0; m_pv = 0; m_pd = 8'h00; m_cyc = 32'h0;
        for (int i = 0; i < 1500; i++) begin
            int k;
            reset = ($urandom_range(0, 199) == 0);
            we = ($urandom_range(0, 99) < 45);
            k = $urandom_range(0, 11);
            if (k < 5)       address = BASE + 32'($urandom_range(0, 3));
            else if (k < 10) address = BASE + 32'($urandom_range(0, 15));
            else if (k == 10) address = BASE + 32'h10 + 32'($urandom_range(0, 15));
            else             address = $urandom;
            data_in  = $urandom;
            func_in  = 2'($urandom_range(0, 3));
            func_out = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            check($sformatf("rnd_rd[%0d]", i), data_out, model_read(address, func_out));
            check($sformatf("rnd_hit[%0d]", i), 32'(hit), 32'(address[31:4] == BASE[31:4]));
            check($sformatf("rnd_valid[%0d]", i), 32'(out_valid), 32'(m_pv));
            if (m_pv) check($sformatf("rnd_data[%0d]", i), 32'(out_data), 32'(m_pd));
            @(posedge clock);
            model_step();
            #1;
        end
        reset = 1'b0; we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
